vga_bounce_box: RTL
===================

// Module: vga_bounce_box
// PURPOSE
// - Pixel stage downstream of the VGA sync generator. Consumes hsync/vsync/display-on/x/y.
// - Draws a square sprite that bounces off the screen edges over a blue 32-px grid.
// - Emits sync and 1-bit R/G/B, pipeline-aligned, straight to the PMOD VGA pins.
// - Owns the per-frame motion FSM; position changes only during vertical sync (no tearing).
// PARAMETERS
// - H_ACTIVE   800  visible pixels per line
// - V_ACTIVE   600  visible lines per frame
// - BOX_SIZE   32   sprite edge length, pixels (1..V_ACTIVE)
// - STEP       2    pixels moved per axis per frame (1..BOX_SIZE)
// - VS_POL     1    vsync_in asserted level (1 = active-high); frame tick on its assert edge
// PORTS
// - clk          in   1   pixel clock
// - rst          in   1   asynchronous, active-low reset
// - hsync_in     in   1   horizontal sync from the sync generator
// - vsync_in     in   1   vertical sync from the sync generator
// - display_on   in   1   high during the visible area
// - x            in   11  current pixel column
// - y            in   10  current pixel row
// - run          in   1   1 = sprite moves each frame; 0 = frozen
// - hsync_out    out  1   hsync_in delayed 2 clk
// - vsync_out    out  1   vsync_in delayed 2 clk
// - red/green/blue out 1  pixel colour, aligned with the delayed syncs
// - corner_hit   out  1   1-clk pulse when both axes bounce in the same frame update
// BEHAVIOUR
// - Reset (rst=0, async): box_x=0, box_y=0, dir_x=+, dir_y=+, FSM=IDLE, RGB=0, corner_hit=0.
//   Sync pipeline regs reset to the inactive level: hsync_out=vsync_out=~VS_POL.
// - Pixel pipeline, latency 2; valid-in = display_on, no backpressure:
//   - S1: register in_box = box_x<=x<box_x+BOX_SIZE && box_y<=y<box_y+BOX_SIZE.
//     Also register grid = (x[4:0]==0)||(y[4:0]==0), display_on, and both syncs.
//   - S2: priority colour.
//     - !display_on -> RGB 000.
//     - in_box -> RGB 110 (yellow).
//     - grid -> RGB 001 (blue).
//     - otherwise 000.
//   - Compares use 12-bit unsigned (box_x+BOX_SIZE can exceed 11 bits).
// - Frame tick: vsync_in registered once; tick = level moves to VS_POL (one per frame).
// - FSM: IDLE -> MOVE_X on tick && run; MOVE_X -> MOVE_Y; MOVE_Y -> DONE; DONE -> IDLE.
//   - A tick with run=0 stays in IDLE.
//   - A tick arriving outside IDLE is ignored (cannot occur at legal timings).
// - MOVE_X, dir + : if box_x+BOX_SIZE+STEP > H_ACTIVE then box_x=H_ACTIVE-BOX_SIZE, dir_x=-, bx=1.
//   Otherwise box_x += STEP.
// - MOVE_X, dir - : if box_x < STEP then box_x=0, dir_x=+, bx=1. Otherwise box_x -= STEP.
// - MOVE_Y: same rules with V_ACTIVE, box_y, dir_y, by.
// - DONE: corner_hit=1 for exactly this clk if bx&&by. Then clear bx/by.
// - Position regs are read by S1 every clk. They change only inside vsync, so every
//   visible frame shows one consistent position.
// - run deasserted mid-frame: the current update completes; the next tick is ignored.
// - rst asserted mid-frame: immediate return to reset state. Outputs black until sync resumes.
// STRUCTURE
// - Shared include vga_params.vh holds H_ACTIVE/V_ACTIVE/sync polarity defines.
//   vga_sync and this block both use it.
// - One sub-module: vga_frame_tick (vsync edge detector, VS_POL parameter, 1-clk tick out).
// - Pixel pipeline and motion FSM stay inline in this module.
// TESTING
// - Reset: hold rst=0 with random inputs -> RGB=000, sync outs=~VS_POL, corner_hit=0.
//   Release -> box at (0,0).
// - Alignment: drive x=5,y=5,display_on=1 -> RGB=110 exactly 2 clk later.
//   Syncs delayed the same 2 clk; x=64,y=3 -> 001; display_on=0 -> 000.
// - Motion: 10 ticks with run=1 -> box_x=20, box_y=20.
//   Then run=0 plus 5 ticks -> unchanged.
// - Right bounce: preload box_x=767, dir + (H=800, size 32, step 2) -> box_x=768, dir -.
//   Next tick -> 766.
// - Corner: box_x=767, box_y=567, both dir + -> one tick gives (768,568).
//   corner_hit pulses exactly 1 clk; both dirs flip.
// - Async reset mid-MOVE_Y -> all regs reset within the same clk, without waiting for an edge.

Source files
------------

// File: rtl/vga_bounce_box_pkg.sv
// Shared types, default screen geometry and the per-axis bounce rule for
// the bouncing-box pixel stage.
package vga_bounce_box_pkg;

  localparam int H_ACTIVE_DEF = 800;
  localparam int V_ACTIVE_DEF = 600;
  localparam int BOX_SIZE_DEF = 32;
  localparam int STEP_DEF     = 2;
  localparam bit VS_POL_DEF   = 1'b1;

  localparam logic DIR_POS = 1'b0;
  localparam logic DIR_NEG = 1'b1;

  typedef enum logic [1:0] {IDLE, MOVE_X, MOVE_Y, DONE} state_t;

  typedef struct packed {
    state_t      state;
    logic [10:0] box_x;
    logic [9:0]  box_y;
    logic        dir_x;
    logic        dir_y;
  } dbg_t;

  typedef struct packed {
    logic [11:0] pos;
    logic        dir;
    logic        hit;
  } axis_t;

  // One axis update: advance by step, or clamp to the edge and reverse.
  function automatic axis_t axis_step(input logic [11:0] pos, input logic dir,
                                      input logic [11:0] limit, input logic [11:0] size,
                                      input logic [11:0] step);
    axis_t r;
    r.pos = pos;
    r.dir = dir;
    r.hit = 1'b0;
    if (dir == DIR_POS) begin
      if (pos + size + step > limit) begin
        r.pos = limit - size;
        r.dir = DIR_NEG;
        r.hit = 1'b1;
      end else begin
        r.pos = pos + step;
      end
    end else begin
      if (pos < step) begin
        r.pos = '0;
        r.dir = DIR_POS;
        r.hit = 1'b1;
      end else begin
        r.pos = pos - step;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/vga_frame_tick.sv
// Vertical-sync edge detector: one-clock tick when vsync moves to its asserted level.
module vga_frame_tick #(
  parameter bit VS_POL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic vsync,
  output logic tick
);

  logic vsync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vsync_q <= ~VS_POL;
    else      vsync_q <= vsync;
  end

  assign tick = (vsync == VS_POL) && (vsync_q != VS_POL);

endmodule

// File: rtl/vga_bounce_box.sv
// Pixel stage: 2-clk pipeline drawing a bouncing yellow box over a blue grid,
// with a per-frame motion FSM that only moves the box during vertical sync.
module vga_bounce_box
  import vga_bounce_box_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int BOX_SIZE = BOX_SIZE_DEF,
  parameter int STEP     = STEP_DEF,
  parameter bit VS_POL   = VS_POL_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        display_on,
  input  logic [10:0] x,
  input  logic [9:0]  y,
  input  logic        run,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        red,
  output logic        green,
  output logic        blue,
  output logic        corner_hit,
  output dbg_t        dbg
);

  localparam logic [11:0] H12    = 12'(H_ACTIVE);
  localparam logic [11:0] V12    = 12'(V_ACTIVE);
  localparam logic [11:0] SIZE12 = 12'(BOX_SIZE);
  localparam logic [11:0] STEP12 = 12'(STEP);

  logic        tick;
  state_t      state, state_d;
  logic [11:0] box_x, box_x_d, box_y, box_y_d;
  logic        dir_x, dir_x_d, dir_y, dir_y_d;
  logic        bx, bx_d, by, by_d;
  axis_t       ax, ay;

  vga_frame_tick #(.VS_POL(VS_POL)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .vsync (vsync_in),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      box_x <= '0;
      box_y <= '0;
      dir_x <= DIR_POS;
      dir_y <= DIR_POS;
      bx    <= 1'b0;
      by    <= 1'b0;
    end else begin
      state <= state_d;
      box_x <= box_x_d;
      box_y <= box_y_d;
      dir_x <= dir_x_d;
      dir_y <= dir_y_d;
      bx    <= bx_d;
      by    <= by_d;
    end
  end

  // A tick outside IDLE is dropped; the sequence always completes once started.
  always_comb begin
    state_d = state;
    box_x_d = box_x;
    box_y_d = box_y;
    dir_x_d = dir_x;
    dir_y_d = dir_y;
    bx_d    = bx;
    by_d    = by;
    ax      = axis_step(box_x, dir_x, H12, SIZE12, STEP12);
    ay      = axis_step(box_y, dir_y, V12, SIZE12, STEP12);
    case (state)
      IDLE:   if (tick && run) state_d = MOVE_X;
      MOVE_X: begin
        box_x_d = ax.pos;
        dir_x_d = ax.dir;
        bx_d    = ax.hit;
        state_d = MOVE_Y;
      end
      MOVE_Y: begin
        box_y_d = ay.pos;
        dir_y_d = ay.dir;
        by_d    = ay.hit;
        state_d = DONE;
      end
      DONE: begin
        bx_d    = 1'b0;
        by_d    = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign corner_hit = (state == DONE) && bx && by;

  always_comb begin
    dbg.state = state;
    dbg.box_x = box_x[10:0];
    dbg.box_y = box_y[9:0];
    dbg.dir_x = dir_x;
    dbg.dir_y = dir_y;
  end

  // Pixel pipeline; compares are 12-bit since box_x + BOX_SIZE can exceed 11 bits.
  logic       in_box_q, grid_q, de_q, hs_q, vs_q;
  logic [2:0] rgb;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_box_q  <= 1'b0;
      grid_q    <= 1'b0;
      de_q      <= 1'b0;
      hs_q      <= ~VS_POL;
      vs_q      <= ~VS_POL;
      rgb       <= 3'b000;
      hsync_out <= ~VS_POL;
      vsync_out <= ~VS_POL;
    end else begin
      in_box_q  <= ({1'b0, x} >= box_x) && ({1'b0, x} < box_x + SIZE12) &&
                   ({2'b0, y} >= box_y) && ({2'b0, y} < box_y + SIZE12);
      grid_q    <= (x[4:0] == 5'd0) || (y[4:0] == 5'd0);
      de_q      <= display_on;
      hs_q      <= hsync_in;
      vs_q      <= vsync_in;
      hsync_out <= hs_q;
      vsync_out <= vs_q;
      if (!de_q)         rgb <= 3'b000;
      else if (in_box_q) rgb <= 3'b110;
      else if (grid_q)   rgb <= 3'b001;
      else               rgb <= 3'b000;
    end
  end

  assign red   = rgb[2];
  assign green = rgb[1];
  assign blue  = rgb[0];

endmodule
